// File: rtl/oam_dma_arbiter_pkg.sv
// Shared CPU-side package: bus operation encoding, OAM DMA state encoding
// and the default bus addresses used by the OAM DMA arbiter.
package oam_dma_arbiter_pkg;

  // CPU write address that starts an OAM DMA transfer.
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  // Destination address for every DMA write (OAM data port).
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  // Bus operation issued by a bus master in a given cycle.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } bus_op_t;

  // OAM DMA sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: a CPU write of a page number to DMA_REG_ADDR stalls the
// CPU, takes the shared bus and copies 256 bytes from {page, 8'h00..8'hFF}
// to OAM_DATA_ADDR as alternating read/write cycles. An extra ALIGN cycle
// is inserted when the halt lands on an odd cycle of the free-running
// parity bit.
//
// Ports:
//   CLK        system clock, all state updates on posedge
//   RESET      synchronous, active-high reset
//   cpu_addr   CPU bus address for the current cycle
//   cpu_wdata  CPU write data (page number on a trigger write)
//   cpu_we     CPU write strobe
//   mem_rdata  shared-bus read data, valid in the cycle dma_re is high
//   cpu_stall  holds the CPU (RDY low) while a transfer is active
//   dma_grant  bus mux select, 1 = DMA owns the bus
//   dma_addr   DMA bus address
//   dma_wdata  DMA write data
//   dma_re     DMA read strobe
//   dma_we     DMA write strobe
//   dma_busy   high in every state except IDLE
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = oam_dma_arbiter_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = oam_dma_arbiter_pkg::OAM_DATA_ADDR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_stall,
  output logic        dma_grant,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_re,
  output logic        dma_we,
  output logic        dma_busy
);

  import oam_dma_arbiter_pkg::*;

  dma_state_t state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q;
  logic [7:0] index_q;
  logic [7:0] byte_q;
  logic       trigger;
  bus_op_t    op;

  // Only honoured in IDLE; writes elsewhere, or to other addresses, are ignored.
  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (trigger) state_d = ST_HALT;
      ST_HALT:  state_d = parity_q ? ST_ALIGN : ST_READ;
      ST_ALIGN: state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op        = OP_NONE;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    unique case (state_q)
      ST_READ: begin
        op       = OP_READ;
        dma_addr = {page_q, index_q};
      end
      ST_WRITE: begin
        op        = OP_WRITE;
        dma_addr  = OAM_DATA_ADDR;
        dma_wdata = byte_q;
      end
      default: ;
    endcase
  end

  assign dma_re    = (op == OP_READ);
  assign dma_we    = (op == OP_WRITE);
  assign dma_busy  = (state_q != ST_IDLE);
  assign cpu_stall = dma_busy;
  assign dma_grant = dma_busy;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the byte register is reset along with the control state so an
      // aborted transfer never leaves stale data to leak into the next one.
      state_q  <= ST_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (state_q == ST_IDLE && trigger) begin
        page_q  <= cpu_wdata;
        index_q <= 8'h00;
      end
      if (state_q == ST_READ) byte_q <= mem_rdata;
      if (state_q == ST_WRITE) index_q <= index_q + 8'd1;
    end
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, CPU write address that triggers a DMA.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, destination address for every DMA write.
REQ-003 CLK  input  1  system clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  reset; synchronous, active-high.
REQ-005 cpu_addr  input  16  CPU bus address for the current cycle.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 cpu_we  input  1  CPU write strobe.
REQ-008 mem_rdata  input  8  shared-bus read data, valid combinationally in the cycle dma_re is high.
REQ-009 cpu_stall  output  1  holds the CPU controller (RDY low); the CPU performs no bus access while high.
REQ-010 dma_grant  output  1  bus mux select: 1 = DMA owns address/data/strobes, 0 = CPU.
REQ-011 dma_addr  output  16  DMA bus address.
REQ-012 dma_wdata  output  8  DMA write data.
REQ-013 dma_re  output  1  DMA read strobe.
REQ-014 dma_we  output  1  DMA write strobe.
REQ-015 dma_busy  output  1  high in every state except IDLE.

Function
REQ-016 The block SHALL implement states IDLE, HALT, ALIGN, READ and WRITE.
REQ-017 A free-running parity bit SHALL toggle every cycle and reset to 0.
REQ-018 In IDLE, cpu_we=1 with cpu_addr==DMA_REG_ADDR SHALL latch cpu_wdata as page, clear the 8-bit index to 0, and move to HALT.
REQ-019 HALT SHALL last exactly one cycle with no bus strobe, then go to ALIGN if parity==1, otherwise to READ.
REQ-020 ALIGN SHALL last exactly one cycle with no bus strobe, then go to READ.
REQ-021 READ SHALL drive dma_addr={page,index} and dma_re=1, capture mem_rdata into a byte register at the cycle end, and go to WRITE.
REQ-022 WRITE SHALL drive dma_addr=OAM_DATA_ADDR, dma_wdata=captured byte and dma_we=1.
REQ-023 On leaving WRITE, the index SHALL increment; WRITE SHALL go to IDLE when index was 8'hFF, otherwise to READ.
REQ-024 One transfer SHALL therefore copy 256 bytes in 513 cycles (even start) or 514 cycles (odd start), counted from HALT through the last WRITE inclusive.
REQ-025 cpu_stall, dma_grant and dma_busy SHALL be 1 in HALT, ALIGN, READ and WRITE and 0 in IDLE.
REQ-026 dma_re and dma_we SHALL never both be 1, and SHALL be 0 outside READ and WRITE respectively.
REQ-027 In IDLE, dma_addr and dma_wdata SHALL be 0.
REQ-028 Writes to DMA_REG_ADDR while dma_busy=1 SHALL be ignored; page and index SHALL be unchanged.
REQ-029 A trigger in the same cycle as the final WRITE SHALL be ignored.
REQ-030 A trigger on the first IDLE cycle after a transfer SHALL be accepted normally.
REQ-031 Writes to any other address SHALL have no effect on the block.

Reset
REQ-032 RESET=1 SHALL force state IDLE, parity 0, page 0, index 0 and the byte register 0 at the next posedge, overriding any trigger.
REQ-033 RESET asserted mid-transfer SHALL abort the transfer: all outputs are 0 from the cycle after the reset edge, and no further writes occur.

Structure
REQ-034 The state typedef (dma_state_t) and the constants DMA_REG_ADDR and OAM_DATA_ADDR SHALL live in the shared CPU package alongside the existing MUX/operation enums.
REQ-035 The design SHALL be a single module with no sub-modules; the bus mux using dma_grant belongs to the top level.

Verification
REQ-036 Even-start transfer: reset, then write 8'h02 to 16'h4014 with parity 0 -> READ addresses 16'h0200..16'h02FF, 256 writes to 16'h2004 in order, busy for 513 cycles.
REQ-037 Odd-start transfer: same trigger with parity 1 -> one ALIGN cycle, busy for 514 cycles, identical data sequence.
REQ-038 Data integrity: memory page 8'h07 preloaded with byte i = i XOR 8'h5A -> the OAM model receives the same 256 bytes in index order.
REQ-039 Retrigger during busy: write 8'h03 to 16'h4014 at index 8'h40 -> no effect; the transfer completes from page 8'h02.
REQ-040 Reset mid-transfer: assert RESET during WRITE at index 8'h80 -> next cycle all outputs 0, state IDLE; a new trigger restarts from index 0.
REQ-041 Back-to-back transfers: trigger in the first IDLE cycle after a transfer -> accepted; a trigger coincident with the final WRITE -> ignored.
